asynchronous_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer that decouples a producer and a consumer sharing one clock domain. Data words are written on `wr_en` and returned in order on `rd_en`. An occupancy count and full/empty flags are available to surrounding flow-control logic. Storage is a register array of DEPTH words addressed by wrapping read/write pointers.

---
 rtl/asynchronous_fifo.sv | 98 +++++++++
 tb/tb_asynchronous_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo: single-clock register-array FIFO with a registered read port,
// an occupancy count and full/empty flags decoded from that count.
module asynchronous_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 128,
   parameter int PTR        = 8
) (
   input  logic                  clk_w,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] buff_in,
   output logic [DATA_WIDTH-1:0] buff_out,
   output logic [DEPTH-1:0]      fifo_counter,
   output logic                  buf_empty,
   output logic                  buf_full
);

   localparam int AW = PTR - 1;
   localparam logic [AW-1:0]  ADDR_ONE = AW'(1'b1);
   localparam logic [PTR-1:0] CNT_ONE  = PTR'(1'b1);
   localparam logic [PTR-1:0] CNT_FULL = PTR'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [PTR-1:0]        count_r;
   logic [DATA_WIDTH-1:0] buff_out_r;
   logic                  empty_s;
   logic                  full_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;

   assign empty_s = (count_r == {PTR{1'b0}});
   assign full_s  = (count_r == CNT_FULL);

   // Qualify requests against the flags; a rejected request has no side effect.
   always_comb begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
      if (wr_en && !full_s) begin
         wr_acc_s = 1'b1;
      end else begin
         wr_acc_s = 1'b0;
      end
      if (rd_en && !empty_s) begin
         rd_acc_s = 1'b1;
      end else begin
         rd_acc_s = 1'b0;
      end
   end

   // Storage array; contents are intentionally left untouched by reset.
   always_ff @(posedge clk_w) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= buff_in;
      end
   end

   // Write pointer wraps naturally at DEPTH since it is exactly PTR-1 bits wide.
   always_ff @(posedge clk_w or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
      end else if (wr_acc_s) begin
         wr_ptr_r <= wr_ptr_r + ADDR_ONE;
      end
   end

   // Read pointer and registered read data; same-address read sees the old word.
   always_ff @(posedge clk_w or negedge rst) begin
      if (!rst) begin
         rd_ptr_r   <= {AW{1'b0}};
         buff_out_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_acc_s) begin
         rd_ptr_r   <= rd_ptr_r + ADDR_ONE;
         buff_out_r <= mem_r[rd_ptr_r];
      end
   end

   // Occupancy count: net effect of accepted write and read on this edge.
   always_ff @(posedge clk_w or negedge rst) begin
      if (!rst) begin
         count_r <= {PTR{1'b0}};
      end else begin
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign buff_out     = buff_out_r;
   assign fifo_counter = {{(DEPTH-PTR){1'b0}}, count_r};
   assign buf_empty    = empty_s;
   assign buf_full     = full_s;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Scoreboard bench for asynchronous_fifo: a queue-based reference model predicts
// the post-edge state, and a negedge monitor compares it with the DUT outputs.
module tb_asynchronous_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 128;
   localparam int PTR   = 8;

   logic            clk_w;
   logic            rst;
   logic            wr_en;
   logic            rd_en;
   logic [DW-1:0]   buff_in;
   logic [DW-1:0]   buff_out;
   logic [DEPTH-1:0] fifo_counter;
   logic            buf_empty;
   logic            buf_full;

   asynchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR(PTR)) dut (
      .clk_w        (clk_w),
      .rst          (rst),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .buff_in      (buff_in),
      .buff_out     (buff_out),
      .fifo_counter (fifo_counter),
      .buf_empty    (buf_empty),
      .buf_full     (buf_full)
   );

   typedef struct {
      logic [DW-1:0] out;
      int            cnt;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_out;
   int            checks = 0;
   int            errors = 0;

   initial clk_w = 1'b0;
   always #5 clk_w = ~clk_w;

   task automatic check(input string name, input logic [DEPTH-1:0] act, input logic [DEPTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_state(input string tag, input logic [DW-1:0] out, input int cnt);
      check({tag, "_buff_out"}, DEPTH'(buff_out), DEPTH'(out));
      check({tag, "_count"}, fifo_counter, DEPTH'(cnt));
      check({tag, "_empty"}, DEPTH'(buf_empty), DEPTH'(cnt == 0));
      check({tag, "_full"}, DEPTH'(buf_full), DEPTH'(cnt == DEPTH));
   endtask

   // Monitor: every edge produces one expected post-edge state.
   always @(negedge clk_w) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_state("mon", e.out, e.cnt);
      end
   end

   // One clock of stimulus; the reference model is a plain bounded queue.
   task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
      bit   wr_ok;
      bit   rd_ok;
      exp_t e;
      wr_en   = w;
      rd_en   = r;
      buff_in = d;
      @(posedge clk_w);
      wr_ok = w && (model_q.size() < DEPTH);
      rd_ok = r && (model_q.size() > 0);
      if (rd_ok) model_out = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      e.out = model_out;
      e.cnt = model_q.size();
      exp_q.push_back(e);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic mid_reset();
      @(negedge clk_w);
      #1;
      rst = 1'b0;
      #1;
      model_q.delete();
      model_out = {DW{1'b0}};
      check_state("async_rst", model_out, 0);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      buff_in   = {DW{1'b0}};
      model_out = {DW{1'b0}};
      repeat (2) @(posedge clk_w);
      #1;
      check_state("reset", {DW{1'b0}}, 0);
      rst = 1'b1;

      // Ordered transfer, then underflow on empty.
      cycle(1'b1, 1'b0, 32'hA5A5A5A5);
      cycle(1'b0, 1'b0, 32'h0000_0000);
      cycle(1'b0, 1'b0, 32'h0000_0000);
      cycle(1'b1, 1'b0, 32'hB784C3A8);
      cycle(1'b0, 1'b1, 32'h0000_0000);
      cycle(1'b0, 1'b1, 32'h0000_0000);
      cycle(1'b0, 1'b1, 32'h1111_1111);
      cycle(1'b0, 1'b0, 32'h0000_0000);

      // Fill, overflow attempt, drain.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
      cycle(1'b1, 1'b0, 32'hDEADBEEF);
      cycle(1'b1, 1'b1, 32'hCAFE_F00D);
      cycle(1'b1, 1'b0, 32'h0BAD_0BAD);
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 32'h0000_0000);

      // Steady simultaneous traffic across the pointer wrap.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h1000_0000 + DW'(i));
      for (int i = 3; i < 203; i++) cycle(1'b1, 1'b1, 32'h1000_0000 + DW'(i));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h0000_0000);
      cycle(1'b1, 1'b1, 32'h7777_7777);
      cycle(1'b0, 1'b1, 32'h0000_0000);

      // Reset with data in flight, then recover.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h5000_0000 + DW'(i));
      mid_reset();
      cycle(1'b1, 1'b0, 32'h1234_5678);
      cycle(1'b0, 1'b1, 32'h0000_0000);

      // Randomised phases with varying write/read bias to visit full and empty.
      for (int p = 0; p < 6; p++) begin
         int wb;
         int rb;
         wb = (p % 2 == 0) ? 80 : 25;
         rb = (p % 2 == 0) ? 30 : 85;
         for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, $urandom);
         end
      end
      mid_reset();
      cycle(1'b1, 1'b1, 32'hFEED_0001);
      cycle(1'b1, 1'b1, 32'hFEED_0002);
      cycle(1'b0, 1'b1, 32'h0000_0000);

      repeat (3) @(negedge clk_w);
      #1;
      check("scoreboard_drained", DEPTH'(exp_q.size()), {DEPTH{1'b0}});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
